vx_icache_arb: RTL and testbench

VX_ICACHE_ARB -- requirements
Module: VX_icache_arb

---
 rtl/vx_gpu_pkg.sv | 21 ++
 rtl/vx_rr_arbiter.sv | 41 ++++
 rtl/vx_icache_arb.sv | 153 +++++++++++++++
 tb/tb_vx_icache_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_gpu_pkg.sv
// Shared sizing helpers for the GPU fetch-path blocks: counter and index widths
// derived from the requester count and the outstanding-request limit.
package vx_gpu_pkg;

    localparam int DEFAULT_NUM_REQS    = 2;
    localparam int DEFAULT_MAX_PENDING = 4;

    // Width of a counter that must represent 0..max_pending inclusive.
    function automatic int pending_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

    // Width of a requester index; never narrower than one bit.
    function automatic int index_width(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

    localparam int DEFAULT_PENDING_W = pending_width(DEFAULT_MAX_PENDING);
    localparam int DEFAULT_INDEX_W   = index_width(DEFAULT_NUM_REQS);

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin selector: the first asserted request at or after ptr wins,
// wrapping past the top index back to zero.
module vx_rr_arbiter
    import vx_gpu_pkg::*;
#(
    parameter int NUM_REQS = 2,
    parameter int INDEX_W  = index_width(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] requests,
    input  logic [INDEX_W-1:0]  ptr,
    output logic [NUM_REQS-1:0] grant_onehot,
    output logic [INDEX_W-1:0]  grant_index,
    output logic                grant_valid
);

    // Scan from the farthest offset down so the closest one to ptr is kept last.
    always_comb begin
        int idx;
        grant_index = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQS) begin
                idx = idx - NUM_REQS;
            end
            if (requests[idx]) begin
                grant_valid = 1'b1;
                grant_index = INDEX_W'(idx);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQS; gi++) begin : gen_onehot
            assign grant_onehot[gi] = grant_valid && (grant_index == INDEX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/vx_icache_arb.sv
// Shares one icache port among several fetch requesters: round-robin request
// arbitration into a one-entry output register, and tag-routed responses.
module vx_icache_arb
    import vx_gpu_pkg::*;
#(
    parameter int NUM_REQS    = 2,
    parameter int ADDR_WIDTH  = 30,
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 4
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic [NUM_REQS-1:0]            req_valid,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
    output logic [NUM_REQS-1:0]            req_ready,

    output logic                           mem_req_valid,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr,
    output logic [TAG_WIDTH+index_width(NUM_REQS)-1:0] mem_req_tag,
    input  logic                           mem_req_ready,

    input  logic                           mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]          mem_rsp_data,
    input  logic [TAG_WIDTH+index_width(NUM_REQS)-1:0] mem_rsp_tag,
    output logic                           mem_rsp_ready,

    output logic [NUM_REQS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [TAG_WIDTH-1:0]           rsp_tag,
    input  logic [NUM_REQS-1:0]            rsp_ready,

    output logic                           busy
);

    localparam int IW  = index_width(NUM_REQS);
    localparam int PW  = pending_width(MAX_PENDING);
    localparam int MTW = TAG_WIDTH + IW;
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQS - 1);

    logic [PW-1:0]         pending_reg [NUM_REQS];
    logic [PW-1:0]         pending_next [NUM_REQS];
    logic [IW-1:0]         rr_ptr_reg;
    logic [IW-1:0]         rr_ptr_next;
    logic                  out_valid_reg;
    logic [ADDR_WIDTH-1:0] out_addr_reg;
    logic [MTW-1:0]        out_tag_reg;

    logic [NUM_REQS-1:0]   eligible;
    logic [NUM_REQS-1:0]   grant_onehot;
    logic [IW-1:0]         grant_index;
    logic                  grant_valid;
    logic                  can_load;
    logic                  accept;
    logic [NUM_REQS-1:0]   inc_vec;
    logic [NUM_REQS-1:0]   dec_vec;
    logic [NUM_REQS-1:0]   pend_nz;
    logic [NUM_REQS-1:0]   sel_hit;
    logic [IW-1:0]         rsp_sel;
    logic                  sel_in_range;
    logic                  sel_pend_nz;

    vx_rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .INDEX_W  (IW)
    ) u_rr_arbiter (
        .requests     (eligible),
        .ptr          (rr_ptr_reg),
        .grant_onehot (grant_onehot),
        .grant_index  (grant_index),
        .grant_valid  (grant_valid)
    );

    // The output register can take a new entry if empty or draining this cycle.
    assign can_load    = !out_valid_reg || mem_req_ready;
    assign accept      = grant_valid && can_load && !reset;
    assign req_ready   = accept ? grant_onehot : '0;
    assign rr_ptr_next = (grant_index == LAST_IDX) ? '0 : grant_index + IW'(1);
    assign inc_vec     = accept ? grant_onehot : '0;

    assign rsp_sel     = mem_rsp_tag[MTW-1:TAG_WIDTH];
    assign rsp_tag     = mem_rsp_tag[TAG_WIDTH-1:0];
    assign rsp_data    = mem_rsp_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQS; gi++) begin : gen_req
            assign eligible[gi]  = req_valid[gi] && (pending_reg[gi] < PEND_MAX);
            assign pend_nz[gi]   = (pending_reg[gi] != '0);
            assign sel_hit[gi]   = (rsp_sel == IW'(gi));
            assign rsp_valid[gi] = mem_rsp_valid && sel_hit[gi] && !reset;
            assign dec_vec[gi]   = rsp_valid[gi] && rsp_ready[gi];

            // Simultaneous issue and retire leaves the count unchanged.
            always_comb begin
                pending_next[gi] = pending_reg[gi];
                if (inc_vec[gi] && !dec_vec[gi]) begin
                    pending_next[gi] = pending_reg[gi] + PW'(1);
                end else if (!inc_vec[gi] && dec_vec[gi]) begin
                    pending_next[gi] = pending_reg[gi] - PW'(1);
                end
            end
        end
    endgenerate

    assign sel_in_range  = |sel_hit;
    assign sel_pend_nz   = |(sel_hit & pend_nz);
    assign mem_rsp_ready = (|(sel_hit & rsp_ready)) && !reset;

    assign mem_req_valid = out_valid_reg && !reset;
    assign mem_req_addr  = out_addr_reg;
    assign mem_req_tag   = out_tag_reg;
    assign busy          = ((|pend_nz) || out_valid_reg) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            rr_ptr_reg    <= '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                pending_reg[i] <= '0;
            end
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                rr_ptr_reg    <= rr_ptr_next;
            end else if (mem_req_ready) begin
                out_valid_reg <= 1'b0;
            end
            for (int i = 0; i < NUM_REQS; i++) begin
                pending_reg[i] <= pending_next[i];
            end
        end
    end

    // Payload only changes on acceptance, so it stays put while stalled.
    always_ff @(posedge clk) begin
        if (accept) begin
            out_addr_reg <= req_addr[int'(grant_index)*ADDR_WIDTH +: ADDR_WIDTH];
            out_tag_reg  <= {grant_index, req_tag[int'(grant_index)*TAG_WIDTH +: TAG_WIDTH]};
        end
    end

    // A response must target an existing requester that has something outstanding.
    always_ff @(posedge clk) begin
        if (!reset && mem_rsp_valid) begin
            assert (sel_in_range && sel_pend_nz);
        end
    end

endmodule

// File: tb/tb_vx_icache_arb.sv
// Directed bench for vx_icache_arb: a per-cycle vector table followed by
// hand-written sequences for pending limit, response backpressure and reset.
module tb_vx_icache_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [59:0] req_addr;
    logic [15:0] req_tag;
    logic [1:0]  req_ready;
    logic        mem_req_valid;
    logic [29:0] mem_req_addr;
    logic [8:0]  mem_req_tag;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [8:0]  mem_rsp_tag;
    logic        mem_rsp_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_tag;
    logic [1:0]  rsp_ready;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vx_icache_arb #(
        .NUM_REQS    (2),
        .ADDR_WIDTH  (30),
        .DATA_WIDTH  (32),
        .TAG_WIDTH   (8),
        .MAX_PENDING (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_tag       (req_tag),
        .req_ready     (req_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_tag   (mem_req_tag),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_tag   (mem_rsp_tag),
        .mem_rsp_ready (mem_rsp_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .rsp_ready     (rsp_ready),
        .busy          (busy)
    );

    typedef struct {
        logic [1:0]  rv;
        logic [29:0] a0;
        logic [7:0]  t0;
        logic        mrr;
        logic        mrv;
        logic [8:0]  mtag;
        logic [1:0]  rr;
        logic [1:0]  e_rdy;
        logic        e_mv;
        logic [29:0] e_maddr;
        logic [8:0]  e_mtag;
        logic [1:0]  e_rsv;
        logic        e_mrr;
        logic        e_busy;
        logic [2:0]  e_p0;
        logic [2:0]  e_p1;
        logic        e_ptr;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic drive(input logic [1:0] rv, input logic [29:0] a0, input logic [7:0] t0,
                         input logic [29:0] a1, input logic [7:0] t1, input logic mrr,
                         input logic mrv, input logic [8:0] mtag, input logic [1:0] rr);
        req_valid     = rv;
        req_addr      = {a1, a0};
        req_tag       = {t1, t0};
        mem_req_ready = mrr;
        mem_rsp_valid = mrv;
        mem_rsp_tag   = mtag;
        mem_rsp_data  = 32'hC0DE_0000 | {23'h0, mtag};
        rsp_ready     = rr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  exp_tag;
        logic [31:0] exp_data;

        //           rv     a0       t0     mrr   mrv   mtag    rr     rdy    mv    maddr     mtag    rsv    mrr   busy  p0    p1    ptr
        vecs[0]  = '{2'b11, 30'h1000, 8'h01, 1'b1, 1'b0, 9'h000, 2'b00, 2'b01, 1'b0, 30'h0,    9'h000, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
        vecs[1]  = '{2'b11, 30'h1001, 8'h02, 1'b1, 1'b0, 9'h000, 2'b00, 2'b10, 1'b1, 30'h1000, 9'h001, 2'b00, 1'b0, 1'b1, 3'd1, 3'd0, 1'b1};
        vecs[2]  = '{2'b11, 30'h1002, 8'h03, 1'b1, 1'b0, 9'h000, 2'b00, 2'b01, 1'b1, 30'h2001, 9'h181, 2'b00, 1'b0, 1'b1, 3'd1, 3'd1, 1'b0};
        vecs[3]  = '{2'b11, 30'h1003, 8'h04, 1'b1, 1'b0, 9'h000, 2'b00, 2'b10, 1'b1, 30'h1002, 9'h003, 2'b00, 1'b0, 1'b1, 3'd2, 3'd1, 1'b1};
        vecs[4]  = '{2'b00, 30'h0,    8'h00, 1'b1, 1'b0, 9'h000, 2'b00, 2'b00, 1'b1, 30'h2003, 9'h183, 2'b00, 1'b0, 1'b1, 3'd2, 3'd2, 1'b0};
        vecs[5]  = '{2'b00, 30'h0,    8'h00, 1'b1, 1'b1, 9'h011, 2'b01, 2'b00, 1'b0, 30'h0,    9'h000, 2'b01, 1'b1, 1'b1, 3'd2, 3'd2, 1'b0};
        vecs[6]  = '{2'b00, 30'h0,    8'h00, 1'b1, 1'b1, 9'h012, 2'b11, 2'b00, 1'b0, 30'h0,    9'h000, 2'b01, 1'b1, 1'b1, 3'd1, 3'd2, 1'b0};
        vecs[7]  = '{2'b00, 30'h0,    8'h00, 1'b1, 1'b1, 9'h113, 2'b10, 2'b00, 1'b0, 30'h0,    9'h000, 2'b10, 1'b1, 1'b1, 3'd0, 3'd2, 1'b0};
        vecs[8]  = '{2'b00, 30'h0,    8'h00, 1'b1, 1'b1, 9'h114, 2'b11, 2'b00, 1'b0, 30'h0,    9'h000, 2'b10, 1'b1, 1'b1, 3'd0, 3'd1, 1'b0};
        vecs[9]  = '{2'b00, 30'h0,    8'h00, 1'b1, 1'b0, 9'h000, 2'b00, 2'b00, 1'b0, 30'h0,    9'h000, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
        vecs[10] = '{2'b01, 30'h100,  8'h55, 1'b0, 1'b0, 9'h000, 2'b00, 2'b01, 1'b0, 30'h0,    9'h000, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
        vecs[11] = '{2'b01, 30'h104,  8'h56, 1'b0, 1'b0, 9'h000, 2'b00, 2'b00, 1'b1, 30'h100,  9'h055, 2'b00, 1'b0, 1'b1, 3'd1, 3'd0, 1'b1};
        vecs[12] = '{2'b01, 30'h104,  8'h56, 1'b0, 1'b0, 9'h000, 2'b00, 2'b00, 1'b1, 30'h100,  9'h055, 2'b00, 1'b0, 1'b1, 3'd1, 3'd0, 1'b1};
        vecs[13] = '{2'b01, 30'h104,  8'h56, 1'b0, 1'b0, 9'h000, 2'b00, 2'b00, 1'b1, 30'h100,  9'h055, 2'b00, 1'b0, 1'b1, 3'd1, 3'd0, 1'b1};
        vecs[14] = '{2'b01, 30'h104,  8'h56, 1'b1, 1'b0, 9'h000, 2'b00, 2'b01, 1'b1, 30'h100,  9'h055, 2'b00, 1'b0, 1'b1, 3'd1, 3'd0, 1'b1};
        vecs[15] = '{2'b00, 30'h0,    8'h00, 1'b1, 1'b0, 9'h000, 2'b00, 2'b00, 1'b1, 30'h104,  9'h056, 2'b00, 1'b0, 1'b1, 3'd2, 3'd0, 1'b1};
        vecs[16] = '{2'b01, 30'h108,  8'h57, 1'b1, 1'b1, 9'h021, 2'b01, 2'b01, 1'b0, 30'h0,    9'h000, 2'b01, 1'b1, 1'b1, 3'd2, 3'd0, 1'b1};
        vecs[17] = '{2'b00, 30'h0,    8'h00, 1'b1, 1'b0, 9'h000, 2'b00, 2'b00, 1'b1, 30'h108,  9'h057, 2'b00, 1'b0, 1'b1, 3'd2, 3'd0, 1'b1};
        vecs[18] = '{2'b00, 30'h0,    8'h00, 1'b1, 1'b1, 9'h022, 2'b01, 2'b00, 1'b0, 30'h0,    9'h000, 2'b01, 1'b1, 1'b1, 3'd2, 3'd0, 1'b1};
        vecs[19] = '{2'b00, 30'h0,    8'h00, 1'b1, 1'b1, 9'h023, 2'b01, 2'b00, 1'b0, 30'h0,    9'h000, 2'b01, 1'b1, 1'b1, 3'd1, 3'd0, 1'b1};
        vecs[20] = '{2'b00, 30'h0,    8'h00, 1'b1, 1'b0, 9'h000, 2'b00, 2'b00, 1'b0, 30'h0,    9'h000, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1};

        // Reset, with live-looking inputs to show outputs are forced low.
        reset = 1'b1;
        drive(2'b11, 30'h7, 8'h7, 30'h8, 8'h8, 1'b1, 1'b1, 9'h000, 2'b11);
        step();
        step();
        @(negedge clk);
        chk("rst_mem_req_valid", 0, 32'(mem_req_valid), 32'h0);
        chk("rst_req_ready",     0, 32'(req_ready),     32'h0);
        chk("rst_rsp_valid",     0, 32'(rsp_valid),     32'h0);
        chk("rst_mem_rsp_ready", 0, 32'(mem_rsp_ready), 32'h0);
        chk("rst_busy",          0, 32'(busy),          32'h0);
        step();
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rv, vecs[i].a0, vecs[i].t0, 30'h2000 + 30'(i), 8'h80 + 8'(i),
                  vecs[i].mrr, vecs[i].mrv, vecs[i].mtag, vecs[i].rr);
            @(negedge clk);
            chk("req_ready",     i, 32'(req_ready),      32'(vecs[i].e_rdy));
            chk("mem_req_valid", i, 32'(mem_req_valid),  32'(vecs[i].e_mv));
            if (vecs[i].e_mv) begin
                chk("mem_req_addr", i, 32'(mem_req_addr), 32'(vecs[i].e_maddr));
                chk("mem_req_tag",  i, 32'(mem_req_tag),  32'(vecs[i].e_mtag));
            end
            chk("rsp_valid",     i, 32'(rsp_valid),      32'(vecs[i].e_rsv));
            chk("mem_rsp_ready", i, 32'(mem_rsp_ready),  32'(vecs[i].e_mrr));
            if (vecs[i].mrv) begin
                exp_tag  = vecs[i].mtag[7:0];
                exp_data = 32'hC0DE_0000 | {23'h0, vecs[i].mtag};
                chk("rsp_tag",  i, 32'(rsp_tag), 32'(exp_tag));
                chk("rsp_data", i, rsp_data,     exp_data);
            end
            chk("busy",          i, 32'(busy),             32'(vecs[i].e_busy));
            chk("pending0",      i, 32'(dut.pending_reg[0]), 32'(vecs[i].e_p0));
            chk("pending1",      i, 32'(dut.pending_reg[1]), 32'(vecs[i].e_p1));
            chk("rr_ptr",        i, 32'(dut.rr_ptr_reg),   32'(vecs[i].e_ptr));
            $display("vec %0d: req_ready=%b mem_req_valid=%b addr=0x%0h tag=0x%0h rsp_valid=%b busy=%b",
                     i, req_ready, mem_req_valid, mem_req_addr, mem_req_tag, rsp_valid, busy);
            step();
        end

        // Requester 0 fills to its limit; requester 1 keeps getting every slot.
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 30'h400 + 30'(k), 8'h40 + 8'(k), 30'h0, 8'h0, 1'b1, 1'b0, 9'h0, 2'b00);
            @(negedge clk);
            chk("lim_fill_ready", k, 32'(req_ready), 32'h1);
            $display("limit fill %0d: req_ready=%b pending0=%0d", k, req_ready, dut.pending_reg[0]);
            step();
        end
        drive(2'b01, 30'h404, 8'h44, 30'h0, 8'h0, 1'b1, 1'b0, 9'h0, 2'b00);
        @(negedge clk);
        chk("lim_full_ready", 4, 32'(req_ready),          32'h0);
        chk("lim_full_pend0", 4, 32'(dut.pending_reg[0]), 32'd4);
        $display("limit full: req_ready=%b pending0=%0d", req_ready, dut.pending_reg[0]);
        step();
        for (int k = 5; k < 8; k++) begin
            drive(2'b11, 30'h404, 8'h44, 30'h300 + 30'(k), 8'h30 + 8'(k), 1'b1, 1'b0, 9'h0, 2'b00);
            @(negedge clk);
            chk("lim_skip_ready", k, 32'(req_ready), 32'h2);
            if (k > 5) begin
                chk("lim_skip_addr", k, 32'(mem_req_addr), 32'h300 + 32'(k - 1));
            end
            $display("limit skip %0d: req_ready=%b addr=0x%0h", k, req_ready, mem_req_addr);
            step();
        end
        drive(2'b00, 30'h0, 8'h0, 30'h0, 8'h0, 1'b1, 1'b0, 9'h0, 2'b00);
        @(negedge clk);
        chk("lim_last_addr", 8, 32'(mem_req_addr),      32'h307);
        chk("lim_pend1",     8, 32'(dut.pending_reg[1]), 32'd3);
        step();
        for (int j = 0; j < 7; j++) begin
            drive(2'b00, 30'h0, 8'h0, 30'h0, 8'h0, 1'b1, 1'b1,
                  (j < 4) ? 9'(j) : 9'h100 + 9'(j), 2'b11);
            @(negedge clk);
            chk("lim_drain_mrr", j, 32'(mem_rsp_ready), 32'h1);
            step();
        end
        drive(2'b00, 30'h0, 8'h0, 30'h0, 8'h0, 1'b1, 1'b0, 9'h0, 2'b00);
        @(negedge clk);
        chk("lim_idle_busy", 9, 32'(busy), 32'h0);
        $display("limit drained: busy=%b pending0=%0d pending1=%0d",
                 busy, dut.pending_reg[0], dut.pending_reg[1]);
        step();

        // Response to requester 1 held off by rsp_ready, then released.
        drive(2'b10, 30'h0, 8'h0, 30'h500, 8'h2A, 1'b1, 1'b0, 9'h0, 2'b00);
        @(negedge clk);
        chk("bp_req_ready", 0, 32'(req_ready), 32'h2);
        step();
        drive(2'b00, 30'h0, 8'h0, 30'h0, 8'h0, 1'b1, 1'b0, 9'h0, 2'b00);
        step();
        drive(2'b00, 30'h0, 8'h0, 30'h0, 8'h0, 1'b1, 1'b1, 9'h12A, 2'b00);
        @(negedge clk);
        chk("bp_rsp_valid",     1, 32'(rsp_valid),          32'h2);
        chk("bp_rsp_tag",       1, 32'(rsp_tag),            32'h2A);
        chk("bp_mem_rsp_ready", 1, 32'(mem_rsp_ready),      32'h0);
        chk("bp_pend1_held",    1, 32'(dut.pending_reg[1]), 32'd1);
        $display("rsp backpressure: rsp_valid=%b rsp_tag=0x%0h mem_rsp_ready=%b",
                 rsp_valid, rsp_tag, mem_rsp_ready);
        step();
        @(negedge clk);
        chk("bp_pend1_stall", 2, 32'(dut.pending_reg[1]), 32'd1);
        rsp_ready = 2'b10;
        #1;
        chk("bp_mem_rsp_ready_up", 2, 32'(mem_rsp_ready), 32'h1);
        step();
        drive(2'b00, 30'h0, 8'h0, 30'h0, 8'h0, 1'b1, 1'b0, 9'h0, 2'b00);
        @(negedge clk);
        chk("bp_pend1_dec", 3, 32'(dut.pending_reg[1]), 32'd0);
        $display("rsp released: pending1=%0d", dut.pending_reg[1]);
        step();

        // Three requests outstanding and the output register full, then reset.
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 30'h600 + 30'(k), 8'h60 + 8'(k), 30'h0, 8'h0, 1'b1, 1'b0, 9'h0, 2'b00);
            step();
        end
        drive(2'b00, 30'h0, 8'h0, 30'h0, 8'h0, 1'b0, 1'b0, 9'h0, 2'b00);
        @(negedge clk);
        chk("mr_busy",  0, 32'(busy),               32'h1);
        chk("mr_mv",    0, 32'(mem_req_valid),      32'h1);
        chk("mr_addr",  0, 32'(mem_req_addr),       32'h602);
        chk("mr_pend0", 0, 32'(dut.pending_reg[0]), 32'd3);
        step();
        reset = 1'b1;
        drive(2'b11, 30'h700, 8'h70, 30'h701, 8'h71, 1'b0, 1'b1, 9'h000, 2'b11);
        @(negedge clk);
        chk("mr_in_rst_mv",    1, 32'(mem_req_valid), 32'h0);
        chk("mr_in_rst_ready", 1, 32'(req_ready),     32'h0);
        chk("mr_in_rst_busy",  1, 32'(busy),          32'h0);
        chk("mr_in_rst_rsv",   1, 32'(rsp_valid),     32'h0);
        chk("mr_in_rst_mrr",   1, 32'(mem_rsp_ready), 32'h0);
        step();
        reset = 1'b0;
        drive(2'b00, 30'h0, 8'h0, 30'h0, 8'h0, 1'b0, 1'b0, 9'h0, 2'b00);
        @(negedge clk);
        chk("mr_after_busy",  2, 32'(busy),               32'h0);
        chk("mr_after_mv",    2, 32'(mem_req_valid),      32'h0);
        chk("mr_after_ptr",   2, 32'(dut.rr_ptr_reg),     32'h0);
        chk("mr_after_pend0", 2, 32'(dut.pending_reg[0]), 32'd0);
        $display("after reset: busy=%b mem_req_valid=%b rr_ptr=%0d", busy, mem_req_valid, dut.rr_ptr_reg);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
